// File: rtl/lcd1602_responder.sv
// HD44780-compatible LCD-side responder: decodes driver bus cycles, holds DDRAM/CGRAM/AC/mode state, models busy timing.
// Define LCD_READBACK_EN to serve status and memory reads back over the bus (rw=1); otherwise reads are ignored.
module lcd1602_responder #(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned BUSY_CYCLES = 2000,
    parameter int unsigned LONG_CYCLES = 82000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rs,
    input  logic       rw,
    input  logic       enable,
    input  logic [7:0] data,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       busy,
    output logic       overrun,
    output logic [6:0] ac,
    output logic       ac_is_cgram,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       two_line,
    output logic       eight_bit,
    output logic       font_5x10,
    output logic       entry_inc,
    output logic       entry_shift,
    output logic [5:0] shift_offset,
    input  logic [6:0] disp_rd_addr,
    output logic [7:0] disp_rd_data,
    input  logic [5:0] cg_rd_addr,
    output logic [7:0] cg_rd_data
);
    typedef enum logic [1:0] {IDLE, DECODE, CLEAR_FILL, BUSY_WAIT} state_t;
    localparam int unsigned CNT_MAX = (LONG_CYCLES > BUSY_CYCLES) ? LONG_CYCLES : BUSY_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] en_sync_q, rs_sync_q, rw_sync_q;
    logic [7:0]             data_sync_q [SYNC_STAGES];
    logic                   en_prev_q;
    logic                   tx_rs_q, tx_rs_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic [6:0]             ac_q, ac_d;
    logic                   cg_q, cg_d, ovr_q, ovr_d;
    logic [5:0]             so_q, so_d;
    logic                   disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
    logic                   lines_q, lines_d, dl_q, dl_d, font_q, font_d, inc_q, inc_d, sh_q, sh_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [6:0]             fill_q, fill_d;
    logic [7:0]             ddram_q [80];
    logic [7:0]             cgram_q [64];
    logic [7:0]             disp_rd_q, cg_rd_q;
    logic                   en_s, rs_s, rw_s, fall, wr_fall, accept;
    logic [7:0]             data_s;

    // HD44780 DDRAM address to linear index 0..79; out-of-range columns fold mod 40 within their row.
    function automatic logic [6:0] dd_index(input logic [6:0] addr);
        logic [5:0] low;
        low = (addr[5:0] >= 6'd40) ? addr[5:0] - 6'd40 : addr[5:0];
        return addr[6] ? {1'b0, low} + 7'd40 : {1'b0, low};
    endfunction

    function automatic logic [6:0] step_ac(input logic [6:0] a, input logic up, input logic cgram);
        if (cgram) return {1'b0, up ? a[5:0] + 6'd1 : a[5:0] - 6'd1};
        if (up) begin
            if (a == 7'h27) return 7'h40;
            if (a == 7'h67) return 7'h00;
            return a + 7'd1;
        end
        if (a == 7'h00) return 7'h67;
        if (a == 7'h40) return 7'h27;
        return a - 7'd1;
    endfunction

    function automatic logic [5:0] step_shift(input logic [5:0] s, input logic up);
        if (up) return (s >= 6'd39) ? 6'd0 : s + 6'd1;
        return (s == 6'd0) ? 6'd39 : s - 6'd1;
    endfunction

    assign en_s    = en_sync_q[SYNC_STAGES-1];
    assign rs_s    = rs_sync_q[SYNC_STAGES-1];
    assign rw_s    = rw_sync_q[SYNC_STAGES-1];
    assign data_s  = data_sync_q[SYNC_STAGES-1];
    assign fall    = en_prev_q & ~en_s;
    assign wr_fall = fall & ~rw_s;
    assign accept  = wr_fall & ~busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            en_sync_q <= '0;
            en_prev_q <= 1'b0;
            ac_q      <= '0;
            cg_q      <= 1'b0;
            ovr_q     <= 1'b0;
            so_q      <= '0;
            disp_q    <= 1'b0;
            cur_q     <= 1'b0;
            blink_q   <= 1'b0;
            lines_q   <= 1'b0;
            dl_q      <= 1'b1;
            font_q    <= 1'b0;
            inc_q     <= 1'b1;
            sh_q      <= 1'b0;
            cnt_q     <= '0;
            fill_q    <= '0;
        end else begin
            state_q      <= state_d;
            en_sync_q[0] <= enable;
            for (int i = 1; i < SYNC_STAGES; i++) en_sync_q[i] <= en_sync_q[i-1];
            en_prev_q    <= en_s;
            ac_q         <= ac_d;
            cg_q         <= cg_d;
            ovr_q        <= ovr_d;
            so_q         <= so_d;
            disp_q       <= disp_d;
            cur_q        <= cur_d;
            blink_q      <= blink_d;
            lines_q      <= lines_d;
            dl_q         <= dl_d;
            font_q       <= font_d;
            inc_q        <= inc_d;
            sh_q         <= sh_d;
            cnt_q        <= cnt_d;
            fill_q       <= fill_d;
        end
    end

    always_ff @(posedge clk) begin
        rs_sync_q[0]   <= rs;
        rw_sync_q[0]   <= rw;
        data_sync_q[0] <= data;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            rs_sync_q[i]   <= rs_sync_q[i-1];
            rw_sync_q[i]   <= rw_sync_q[i-1];
            data_sync_q[i] <= data_sync_q[i-1];
        end
        tx_rs_q   <= tx_rs_d;
        tx_data_q <= tx_data_d;
        if (state_q == DECODE && tx_rs_q) begin
            if (cg_q) cgram_q[ac_q[5:0]] <= tx_data_q;
            else      ddram_q[dd_index(ac_q)] <= tx_data_q;
        end
        if (state_q == CLEAR_FILL) ddram_q[fill_q] <= 8'h20;
        disp_rd_q <= ddram_q[dd_index(disp_rd_addr)];
        cg_rd_q   <= cgram_q[cg_rd_addr];
    end

    // The last BUSY_WAIT cycle already reports not-busy, so a write landing there chains straight into DECODE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (accept) state_d = DECODE;
            DECODE:     state_d = (!tx_rs_q && tx_data_q == 8'h01) ? CLEAR_FILL : BUSY_WAIT;
            CLEAR_FILL: if (fill_q == 7'd79) state_d = BUSY_WAIT;
            BUSY_WAIT:  if (cnt_q == '0) state_d = accept ? DECODE : IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE) && !(state_q == BUSY_WAIT && cnt_q == '0);
    end

    always_comb begin
        tx_rs_d   = tx_rs_q;
        tx_data_d = tx_data_q;
        ac_d      = ac_q;
        cg_d      = cg_q;
        ovr_d     = ovr_q | (wr_fall & busy);
        so_d      = so_q;
        disp_d    = disp_q;
        cur_d     = cur_q;
        blink_d   = blink_q;
        lines_d   = lines_q;
        dl_d      = dl_q;
        font_d    = font_q;
        inc_d     = inc_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        fill_d    = fill_q;
        if (accept) begin
            tx_rs_d   = rs_s;
            tx_data_d = data_s;
        end
        case (state_q)
            DECODE: begin
                cnt_d  = CNT_W'(BUSY_CYCLES - 1);
                fill_d = '0;
                if (tx_rs_q) begin
                    ac_d = step_ac(ac_q, inc_q, cg_q);
                    if (sh_q) so_d = step_shift(so_q, inc_q);
                end else begin
                    casez (tx_data_q)
                        8'b1???????: begin ac_d = tx_data_q[6:0]; cg_d = 1'b0; end
                        8'b01??????: begin ac_d = {1'b0, tx_data_q[5:0]}; cg_d = 1'b1; end
                        8'b001?????: begin dl_d = tx_data_q[4]; lines_d = tx_data_q[3]; font_d = tx_data_q[2]; end
                        8'b0001????: begin
                            if (tx_data_q[3]) so_d = step_shift(so_q, tx_data_q[2]);
                            else              ac_d = step_ac(ac_q, tx_data_q[2], cg_q);
                        end
                        8'b00001???: begin disp_d = tx_data_q[2]; cur_d = tx_data_q[1]; blink_d = tx_data_q[0]; end
                        8'b000001??: begin inc_d = tx_data_q[1]; sh_d = tx_data_q[0]; end
                        8'b0000001?: begin
                            ac_d  = '0;
                            cg_d  = 1'b0;
                            so_d  = '0;
                            cnt_d = CNT_W'(LONG_CYCLES - 1);
                        end
                        8'b00000001: begin ac_d = '0; cg_d = 1'b0; inc_d = 1'b1; so_d = '0; end
                        default: ;
                    endcase
                end
            end
            CLEAR_FILL: begin
                fill_d = fill_q + 7'd1;
                if (fill_q == 7'd79) cnt_d = CNT_W'(LONG_CYCLES - 1);
            end
            BUSY_WAIT: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            default: ;
        endcase
`ifdef LCD_READBACK_EN
        if (fall && rw_s && rs_s && !busy) ac_d = step_ac(ac_q, inc_q, cg_q);
`endif
    end

`ifdef LCD_READBACK_EN
    logic [7:0] rd_mem, dout_q, dout_d;
    logic       doe_q, doe_d;
    assign rd_mem = cg_q ? cgram_q[ac_q[5:0]] : ddram_q[dd_index(ac_q)];
    always_comb begin
        doe_d  = en_s & rw_s;
        dout_d = '0;
        if (doe_d) dout_d = rs_s ? rd_mem : {busy, ac_q};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q <= '0;
            doe_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            doe_q  <= doe_d;
        end
    end
    assign data_out = dout_q;
    assign data_oe  = doe_q;
`else
    assign data_out = '0;
    assign data_oe  = 1'b0;
`endif

    assign overrun      = ovr_q;
    assign ac           = ac_q;
    assign ac_is_cgram  = cg_q;
    assign display_on   = disp_q;
    assign cursor_on    = cur_q;
    assign blink_on     = blink_q;
    assign two_line     = lines_q;
    assign eight_bit    = dl_q;
    assign font_5x10    = font_q;
    assign entry_inc    = inc_q;
    assign entry_shift  = sh_q;
    assign shift_offset = so_q;
    assign disp_rd_data = disp_rd_q;
    assign cg_rd_data   = cg_rd_q;
endmodule

// File: doc/lcd1602_responder.md
Name: lcd1602_responder

Overview:
- HD44780-compatible responder: the LCD side of the 16x2 bus that our lcd1602 drivers initiate.
- Samples rs/rw/enable/data, decodes instructions, and keeps DDRAM (80 B), CGRAM (64 B), the address counter and the mode flags.
- Exposes read ports so a VGA/HDMI renderer can draw the panel, and serves as a bit-accurate bench model for the driver blocks.
- Generates HD44780-style busy timing and flags bus writes that violate it.

Parameters:
- CLK_HZ, 50000000, system clock frequency, used only for documentation of timing.
- BUSY_CYCLES, 2000, busy time after a normal instruction or data write (40 us at 50 MHz).
- LONG_CYCLES, 82000, busy time after clear display or return home (1.64 ms).
- SYNC_STAGES, 2, synchronizer depth on enable, rs, rw and data.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rs  in  1  register select from the driver: 0 = instruction, 1 = data.
- rw  in  1  0 = write, 1 = read.
- enable  in  1  bus strobe; a transaction is latched on its falling edge.
- data  in  8  bus data written by the driver.
- data_out  out  8  read data (see Optional Feature).
- data_oe  out  1  read-drive enable (see Optional Feature).
- busy  out  1  busy flag.
- overrun  out  1  sticky: a write arrived while busy.
- ac  out  7  address counter.
- ac_is_cgram  out  1  1 = ac addresses CGRAM.
- display_on, cursor_on, blink_on  out  1 each  display control bits D/C/B.
- two_line, eight_bit, font_5x10  out  1 each  function-set bits N/DL/F.
- entry_inc, entry_shift  out  1 each  entry-mode bits I/D and S.
- shift_offset  out  6  display shift, range 0..39.
- disp_rd_addr  in  7  DDRAM read address (HD44780 map).
- disp_rd_data  out  8  DDRAM byte; 1-cycle latency.
- cg_rd_addr  in  6  CGRAM read address.
- cg_rd_data  out  8  CGRAM byte; 1-cycle latency.

Behaviour:
- Bus sampling:
  - enable, rs, rw and data each pass through SYNC_STAGES flip-flops.
  - A falling edge on synced enable (previous 1, now 0) latches rs, rw and data into the transaction registers.
- DDRAM map:
  - Address 0x00-0x27 maps to index = addr.
  - Address 0x40-0x67 maps to index = 40 + addr[5:0].
  - Any other address is folded: addr[5:0] is taken mod 40.
- AC stepping on each data access:
  - I/D=1 (increment): 0x27→0x40, 0x67→0x00.
  - I/D=0 (decrement): 0x00→0x67, 0x40→0x27.
  - CGRAM addresses wrap mod 64.
- FSM states: IDLE, DECODE, CLEAR_FILL, BUSY_WAIT.
  - IDLE → DECODE on a latched write when busy=0.
  - A latched write while busy=1 is dropped and sets overrun=1; overrun is cleared only by reset.
  - DECODE lasts 1 cycle and executes by priority of the highest set bit of data:
    - 1xxxxxxx: set DDRAM address. ac = data[6:0], ac_is_cgram = 0.
    - 01xxxxxx: set CGRAM address. ac = data[5:0], ac_is_cgram = 1.
    - 001xxxxx: function set. DL/N/F = data[4]/data[3]/data[2]. eight_bit=0 is only reported; the bus is always treated as 8-bit.
    - 0001xxxx: cursor/display shift. data[3]=1 shifts the display: data[2] R/L moves shift_offset ±1 mod 40. data[3]=0 moves the cursor: ac ±1 with the wrap rules above.
    - 00001xxx: display control, D/C/B = data[2:0].
    - 000001xx: entry mode, I/D = data[1], S = data[0].
    - 00000010 or 00000011: return home. ac = 0, ac_is_cgram = 0, shift_offset = 0, busy time LONG_CYCLES.
    - 00000001: clear display. ac = 0, I/D = 1, shift_offset = 0, next state CLEAR_FILL.
    - 00000000: no-op, busy time BUSY_CYCLES.
    - rs=1 (data write): write to DDRAM or CGRAM at ac, then step ac. If S=1, also shift_offset ±1 mod 40 following I/D.
  - CLEAR_FILL: writes 0x20 into DDRAM indices 0..79, one per cycle (80 cycles), then → BUSY_WAIT with LONG_CYCLES.
  - BUSY_WAIT: busy=1 while a down-counter runs; at 0 → IDLE and busy=0.
- busy rises on the cycle after the latch and stays high through DECODE, CLEAR_FILL and BUSY_WAIT.
- Renderer read ports are independent of the FSM. During CLEAR_FILL they may return a mix of old data and 0x20.
- Reset (including mid-operation):
  - State → IDLE; busy=0, overrun=0, ac=0, ac_is_cgram=0, shift_offset=0.
  - display_on=cursor_on=blink_on=0, entry_inc=1, entry_shift=0, eight_bit=1, two_line=0, font_5x10=0.
  - data_out=0, data_oe=0.
  - Memory contents are not cleared; a reset during CLEAR_FILL leaves DDRAM partially filled.
- A falling edge in the same cycle as the BUSY_WAIT→IDLE transition is accepted (busy is already low).

Optional Feature:
- Macro: LCD_READBACK_EN.
- Defined:
  - While synced enable=1 and rw=1, data_oe=1.
  - rs=0: data_out = {busy, ac}.
  - rs=1: data_out = memory at ac.
  - A read is latched on the falling edge; a data read (rs=1) steps ac and does not set busy.
- Undefined: rw=1 transactions are ignored entirely; data_oe=0 and data_out=0 always.

Test Plan:
- Init: write 0x38, 0x0C, 0x01 with enable pulses spaced at 16 ms → eight_bit=1, two_line=1, display_on=1, cursor_on=0. After the clear, disp_rd_data=0x20 at all 80 indices; ac=0.
- CGRAM: write 0x40, then data 0x0E,0x11,0x11,0x1F,0x11,0x11,0x11,0x00 → cg_rd_data at 0..7 matches, ac=0x08, ac_is_cgram=1.
- DDRAM: write 0x82, then data 0x00, then 0xC2, then data 0x03 → index 2=0x00, index 42=0x03, ac=0x43.
- Wrap: write 0xA7, then data 0x41 → index 39=0x41, ac=0x40. Then write 0x04 and data 0x42 at 0x80 → index 0=0x42, ac=0x67.
- Overrun: write 0x01, then a second enable pulse 10 cycles later → second write ignored, overrun=1, busy held until 80+LONG_CYCLES.
- Reset: assert reset during CLEAR_FILL → next cycle busy=0, ac=0, state IDLE. With LCD_READBACK_EN, a status read returns 0x00.
